// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared opcodes, ALU ops, states and opcode classifier
package multicycle_control_pkg;

  localparam logic [3:0] OP_LD      = 4'b0000;
  localparam logic [3:0] OP_ST      = 4'b0001;
  localparam logic [3:0] OP_R_FIRST = 4'b0010;
  localparam logic [3:0] OP_R_LAST  = 4'b1001;
  localparam logic [3:0] OP_BEQ     = 4'b1011;
  localparam logic [3:0] OP_BNE     = 4'b1100;
  localparam logic [3:0] OP_JMP     = 4'b1101;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERROR  = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_LD, CL_ST, CL_R, CL_BEQ, CL_BNE, CL_JMP, CL_HALT, CL_ILL
  } op_class_e;

  // 1010 and 1110 are the only encodings that fall through to illegal
  function automatic op_class_e op_decode(input logic [3:0] op);
    if (op == OP_LD)                              return CL_LD;
    else if (op == OP_ST)                         return CL_ST;
    else if (op >= OP_R_FIRST && op <= OP_R_LAST) return CL_R;
    else if (op == OP_BEQ)                        return CL_BEQ;
    else if (op == OP_BNE)                        return CL_BNE;
    else if (op == OP_JMP)                        return CL_JMP;
    else if (op == OP_HALT)                       return CL_HALT;
    else                                          return CL_ILL;
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - instruction/data memory request and ready handshake
interface multicycle_control_if;

  logic imem_r;
  logic imem_ready;
  logic mem_r;
  logic mem_w;
  logic dmem_ready;

  modport master (
    output imem_r, mem_r, mem_w,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_r, mem_r, mem_w,
    output imem_ready, dmem_ready
  );

endinterface

// File: rtl/multicycle_control_wait_timer.sv
// rtl/multicycle_control_wait_timer.sv - consecutive ready-low cycle counter with timeout flag
module mc_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (count) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // cnt_q holds prior low cycles, so this fires on the TIMEOUT-th one
  assign expired = count && (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC datapath
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  multicycle_control_if.master mem,
  output logic                ir_w,
  output logic                pc_w,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_to_reg,
  output logic                reg_w,
  output logic                beq,
  output logic                bne,
  output logic                j,
  output logic [1:0]          alu_op,
  output logic [2:0]          state,
  output logic                halted,
  output logic                err,
  output logic [CNT_W-1:0]    retired
);

  state_e           state_q, state_d;
  op_class_e        cls;
  logic             in_wait;
  logic             ready_now;
  logic             expired;
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  assign cls       = op_decode(4'(opcode));
  assign in_wait   = (state_q == FETCH) || (state_q == MEM);
  assign ready_now = (state_q == FETCH) ? mem.imem_ready : mem.dmem_ready;

  // Leaving a wait state always coincides with ready high or with ERROR,
  // so clearing on ready keeps the count per-entry without a comb loop.
  mc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_wait || ready_now),
    .count   (in_wait && !ready_now),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mem.imem_r = 1'b0;
    mem.mem_r  = 1'b0;
    mem.mem_w  = 1'b0;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_w      = 1'b0;
    beq        = 1'b0;
    bne        = 1'b0;
    j          = 1'b0;
    alu_op     = ALU_OP_ADD;
    halted     = 1'b0;
    err        = 1'b0;
    retire     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end

      FETCH: begin
        mem.imem_r = 1'b1;
        if (mem.imem_ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = DECODE;
        end else if (expired) begin
          state_d = ERROR;
        end
      end

      DECODE: begin
        case (cls)
          CL_ILL:  state_d = ERROR;
          CL_HALT: state_d = HALT;
          default: state_d = EXEC;
        endcase
      end

      EXEC: begin
        case (cls)
          CL_LD, CL_ST: begin
            alu_src = 1'b1;
            alu_op  = ALU_OP_ADD;
            state_d = MEM;
          end
          CL_R: begin
            alu_op  = ALU_OP_FUNC;
            state_d = WB;
          end
          CL_BEQ: begin
            beq     = 1'b1;
            alu_op  = ALU_OP_SUB;
            retire  = 1'b1;
            state_d = FETCH;
          end
          CL_BNE: begin
            bne     = 1'b1;
            alu_op  = ALU_OP_SUB;
            retire  = 1'b1;
            state_d = FETCH;
          end
          CL_JMP: begin
            j       = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
          end
          default: state_d = ERROR;
        endcase
      end

      MEM: begin
        alu_src = 1'b1;
        if (cls == CL_ST) mem.mem_w = 1'b1;
        else              mem.mem_r = 1'b1;
        if (mem.dmem_ready) begin
          if (cls == CL_ST) begin
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (expired) begin
          state_d = ERROR;
        end
      end

      WB: begin
        reg_w  = 1'b1;
        retire = 1'b1;
        if (cls == CL_R) reg_dst    = 1'b1;
        else             mem_to_reg = 1'b1;
        state_d = FETCH;
      end

      HALT:  halted = 1'b1;
      ERROR: err    = 1'b1;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - table-driven bench for multicycle_control
module tb_multicycle_control;

  localparam logic [15:0] C_IMEM = 16'h8000;
  localparam logic [15:0] C_IRW  = 16'h4000;
  localparam logic [15:0] C_PCW  = 16'h2000;
  localparam logic [15:0] C_RDST = 16'h1000;
  localparam logic [15:0] C_ASRC = 16'h0800;
  localparam logic [15:0] C_M2R  = 16'h0400;
  localparam logic [15:0] C_REGW = 16'h0200;
  localparam logic [15:0] C_MR   = 16'h0100;
  localparam logic [15:0] C_MW   = 16'h0080;
  localparam logic [15:0] C_BEQ  = 16'h0040;
  localparam logic [15:0] C_BNE  = 16'h0020;
  localparam logic [15:0] C_J    = 16'h0010;
  localparam logic [15:0] C_FUNC = 16'h0008;
  localparam logic [15:0] C_SUB  = 16'h0004;
  localparam logic [15:0] C_HALT = 16'h0002;
  localparam logic [15:0] C_ERR  = 16'h0001;
  localparam logic [15:0] C_F    = C_IMEM | C_IRW | C_PCW;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6, S_ERR = 3'd7;

  typedef struct {
    logic        run;
    logic [3:0]  op;
    logic        ir;
    logic        dr;
    logic [2:0]  st;
    logic [15:0] ctrl;
    logic [15:0] ret;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [3:0]  opcode;
  logic        ir_w, pc_w, reg_dst, alu_src, mem_to_reg, reg_w, beq, bne, j;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic        halted, err;
  logic [15:0] retired;

  int passed = 0;
  int total  = 0;

  multicycle_control_if mif();

  multicycle_control #(.OPCODE_W(4), .TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem(mif),
    .ir_w(ir_w), .pc_w(pc_w), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_w(reg_w), .beq(beq), .bne(bne), .j(j),
    .alu_op(alu_op), .state(state), .halted(halted), .err(err), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [3:0] op, logic ir, logic dr,
                              logic [2:0] st, logic [15:0] ctrl, logic [15:0] ret);
    vec_t v;
    v.run = r; v.op = op; v.ir = ir; v.dr = dr; v.st = st; v.ctrl = ctrl; v.ret = ret;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; opcode = 4'd0;
    mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle's inputs just after a falling edge, check, advance one cycle
  task automatic apply(input vec_t v, input string name);
    logic [15:0] act_ctrl;
    run = v.run; opcode = v.op; mif.imem_ready = v.ir; mif.dmem_ready = v.dr;
    #1;
    act_ctrl = {mif.imem_r, ir_w, pc_w, reg_dst, alu_src, mem_to_reg, reg_w,
                mif.mem_r, mif.mem_w, beq, bne, j, alu_op, halted, err};
    total++;
    if (state === v.st && act_ctrl === v.ctrl && retired === v.ret) begin
      passed++;
    end else begin
      $display("FAIL %s: state/ctrl/retired got %0d/%h/%0d want %0d/%h/%0d",
               name, state, act_ctrl, retired, v.st, v.ctrl, v.ret);
    end
    @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    // ADD, stalled-fetch LD with 3-cycle dmem wait, ST with same wait, BEQ/BNE/JMP
    vecs.push_back(mk(1, 4'b0010, 1, 0, S_IDLE,  16'h0,          0));
    vecs.push_back(mk(0, 4'b0010, 1, 0, S_FETCH, C_F,            0));
    vecs.push_back(mk(0, 4'b0010, 1, 0, S_DEC,   16'h0,          0));
    vecs.push_back(mk(0, 4'b0010, 1, 0, S_EXEC,  C_FUNC,         0));
    vecs.push_back(mk(0, 4'b0010, 1, 0, S_WB,    C_REGW | C_RDST, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, S_FETCH, C_IMEM,         1));
    vecs.push_back(mk(0, 4'b0000, 1, 0, S_FETCH, C_F,            1));
    vecs.push_back(mk(0, 4'b0000, 1, 0, S_DEC,   16'h0,          1));
    vecs.push_back(mk(0, 4'b0000, 1, 0, S_EXEC,  C_ASRC,         1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 4'b0000, 1, 0, S_MEM, C_MR | C_ASRC, 1));
    vecs.push_back(mk(0, 4'b0000, 1, 1, S_MEM,   C_MR | C_ASRC,  1));
    vecs.push_back(mk(0, 4'b0000, 1, 0, S_WB,    C_REGW | C_M2R, 1));
    vecs.push_back(mk(0, 4'b0001, 1, 0, S_FETCH, C_F,            2));
    vecs.push_back(mk(0, 4'b0001, 1, 0, S_DEC,   16'h0,          2));
    vecs.push_back(mk(0, 4'b0001, 1, 0, S_EXEC,  C_ASRC,         2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 4'b0001, 1, 0, S_MEM, C_MW | C_ASRC, 2));
    vecs.push_back(mk(0, 4'b0001, 1, 1, S_MEM,   C_MW | C_ASRC,  2));
    vecs.push_back(mk(0, 4'b1011, 1, 0, S_FETCH, C_F,            3));
    vecs.push_back(mk(0, 4'b1011, 1, 0, S_DEC,   16'h0,          3));
    vecs.push_back(mk(0, 4'b1011, 1, 0, S_EXEC,  C_BEQ | C_SUB,  3));
    vecs.push_back(mk(0, 4'b1100, 1, 0, S_FETCH, C_F,            4));
    vecs.push_back(mk(0, 4'b1100, 1, 0, S_DEC,   16'h0,          4));
    vecs.push_back(mk(0, 4'b1100, 1, 0, S_EXEC,  C_BNE | C_SUB,  4));
    vecs.push_back(mk(0, 4'b1101, 1, 0, S_FETCH, C_F,            5));
    vecs.push_back(mk(0, 4'b1101, 1, 0, S_DEC,   16'h0,          5));
    vecs.push_back(mk(0, 4'b1101, 1, 0, S_EXEC,  C_J,            5));
    vecs.push_back(mk(0, 4'b1101, 0, 0, S_FETCH, C_IMEM,         6));

    do_reset();
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // imem_ready low for 16 fetch cycles -> ERROR, sticky
    do_reset();
    apply(mk(1, 4'b0010, 0, 0, S_IDLE, 16'h0, 0), "to_idle");
    for (int i = 1; i <= 16; i++)
      apply(mk(0, 4'b0010, 0, 0, S_FETCH, C_IMEM, 0), $sformatf("to_wait%0d", i));
    apply(mk(1, 4'b0010, 0, 0, S_ERR, C_ERR, 0), "to_error");
    apply(mk(0, 4'b0010, 1, 1, S_ERR, C_ERR, 0), "to_sticky");

    // ready rises on the 16th cycle: normal advance wins
    do_reset();
    apply(mk(1, 4'b0010, 0, 0, S_IDLE, 16'h0, 0), "tr_idle");
    for (int i = 1; i <= 15; i++)
      apply(mk(0, 4'b0010, 0, 0, S_FETCH, C_IMEM, 0), $sformatf("tr_wait%0d", i));
    apply(mk(0, 4'b0010, 1, 0, S_FETCH, C_F, 0), "tr_ready16");
    apply(mk(0, 4'b0010, 1, 0, S_DEC, 16'h0, 0), "tr_decode");
    apply(mk(0, 4'b0010, 1, 0, S_EXEC, C_FUNC, 0), "tr_exec");

    // JMP retires, then illegal 1010 -> ERROR with retired unchanged
    do_reset();
    apply(mk(1, 4'b1101, 1, 0, S_IDLE,  16'h0, 0), "il_idle");
    apply(mk(0, 4'b1101, 1, 0, S_FETCH, C_F,   0), "il_fetch0");
    apply(mk(0, 4'b1101, 1, 0, S_DEC,   16'h0, 0), "il_dec0");
    apply(mk(0, 4'b1101, 1, 0, S_EXEC,  C_J,   0), "il_jmp");
    apply(mk(0, 4'b1010, 1, 0, S_FETCH, C_F,   1), "il_fetch1");
    apply(mk(0, 4'b1010, 1, 0, S_DEC,   16'h0, 1), "il_dec1");
    apply(mk(1, 4'b1010, 1, 1, S_ERR,   C_ERR, 1), "il_error");
    apply(mk(0, 4'b1010, 1, 1, S_ERR,   C_ERR, 1), "il_sticky");

    // HALT stays put while run toggles
    do_reset();
    apply(mk(1, 4'b1111, 1, 0, S_IDLE,  16'h0, 0), "h_idle");
    apply(mk(1, 4'b1111, 1, 0, S_FETCH, C_F,   0), "h_fetch");
    apply(mk(1, 4'b1111, 1, 0, S_DEC,   16'h0, 0), "h_dec");
    for (int i = 0; i < 4; i++)
      apply(mk(i[0], 4'b1111, 1, 1, S_HALT, C_HALT, 0), $sformatf("h_hold%0d", i));

    // reset while LD waits in MEM; late dmem_ready ignored
    do_reset();
    apply(mk(1, 4'b0010, 1, 0, S_IDLE,  16'h0,          0), "r_idle");
    apply(mk(0, 4'b0010, 1, 0, S_FETCH, C_F,            0), "r_fetch0");
    apply(mk(0, 4'b0010, 1, 0, S_DEC,   16'h0,          0), "r_dec0");
    apply(mk(0, 4'b0010, 1, 0, S_EXEC,  C_FUNC,         0), "r_exec0");
    apply(mk(0, 4'b0010, 1, 0, S_WB,    C_REGW | C_RDST, 0), "r_wb0");
    apply(mk(0, 4'b0000, 1, 0, S_FETCH, C_F,            1), "r_fetch1");
    apply(mk(0, 4'b0000, 1, 0, S_DEC,   16'h0,          1), "r_dec1");
    apply(mk(0, 4'b0000, 1, 0, S_EXEC,  C_ASRC,         1), "r_exec1");
    apply(mk(0, 4'b0000, 1, 0, S_MEM,   C_MR | C_ASRC,  1), "r_mem");
    do_reset();
    apply(mk(0, 4'b0000, 1, 1, S_IDLE, 16'h0, 0), "r_after_rst");
    apply(mk(0, 4'b0000, 1, 1, S_IDLE, 16'h0, 0), "r_late_ready");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the 16-bit RISC datapath. Replaces the single-cycle opcode decode with an FSM that steps each instruction through FETCH / DECODE / EXEC / MEM / WB.
- Drives the same control bundle the datapath already consumes, plus PC/IR write enables and memory request strobes with ready handshakes.
- Adds halt, illegal-opcode and memory-timeout error handling, and a retired-instruction counter.

Parameters:
- OPCODE_W, 4, opcode width.
- TIMEOUT, 16, consecutive cycles with ready low in one wait state before ERROR (min 2).
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  level; leaves IDLE when high.
- opcode  in  OPCODE_W  IR[15:12]; valid from DECODE onward.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data read/write complete this cycle.
- imem_r  out  1  instruction fetch request.
- ir_w  out  1  load IR.
- pc_w  out  1  PC <- PC+2.
- reg_dst, alu_src, mem_to_reg, reg_w, mem_r, mem_w, beq, bne, j  out  1 each  datapath controls.
- alu_op  out  2  00 add (address), 01 sub (compare), 10 func-from-opcode.
- state  out  3  current state encoding.
- halted  out  1  in HALT.
- err  out  1  in ERROR.
- retired  out  CNT_W  instructions completed.

Behaviour:
- Opcode map:
  - 0000 LD; 0001 ST.
  - 0010–1001 R-type ALU ops.
  - 1011 BEQ; 1100 BNE; 1101 JMP; 1111 HALT.
  - 1010, 1110 illegal.
- Reset (any state, any cycle, including mid-wait):
  - state=IDLE, retired=0, wait counter=0.
  - All outputs 0.
  - An outstanding memory request is dropped; its late ready is ignored.
- Outputs:
  - Decoded from state and opcode.
  - ir_w and pc_w in FETCH are qualified by imem_ready (Mealy).
  - All other outputs are Moore.
- IDLE: outputs 0. run=1 -> FETCH.
- FETCH:
  - imem_r=1 every cycle.
  - If imem_ready: ir_w=1, pc_w=1 in the same cycle, then -> DECODE.
- DECODE (1 cycle): register-file read. Illegal -> ERROR; HALT -> HALT; else -> EXEC.
- EXEC (1 cycle):
  - LD/ST: alu_src=1, alu_op=00 -> MEM.
  - R-type: alu_op=10 -> WB.
  - BEQ: beq=1, alu_op=01 -> FETCH.
  - BNE: bne=1, alu_op=01 -> FETCH.
  - JMP: j=1 -> FETCH.
  - The datapath resolves branch taken.
- MEM:
  - LD: mem_r=1, alu_src=1 held; on dmem_ready -> WB.
  - ST: mem_w=1, alu_src=1 held; on dmem_ready -> FETCH.
- WB (1 cycle): reg_w=1.
  - LD: mem_to_reg=1, reg_dst=0.
  - R-type: mem_to_reg=0, reg_dst=1.
  - Then -> FETCH.
- Retirement:
  - retired += 1 (wraps max -> 0) on the final cycle of each instruction: EXEC for branch/jump, MEM completion for ST, WB for LD/R-type.
  - HALT and illegal opcodes do not retire.
- Latency with zero-wait memory (imem_ready/dmem_ready high on the first request cycle):
  - R-type 4 cycles; LD 5; ST 4; branch/jump 3.
- Timeout:
  - Wait counter clears on entry to FETCH or MEM and counts cycles with ready low.
  - On the TIMEOUT-th consecutive low cycle -> ERROR.
  - Ready high on that same cycle wins (normal advance).
- run:
  - Sampled only in IDLE.
  - Dropping run mid-instruction has no effect; the FSM continues fetching.
- HALT / ERROR: all datapath controls 0; halted or err = 1. Sticky until rst.

Decomposition:
- Shared package holds: opcode constants (OP_LD … OP_HALT), ALU_OP_* constants, state encodings (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7).
- One sub-module: mc_wait_timer (counter, clear, timeout flag), instanced once.

Test Plan:
- rst, run=1, ready always high, opcode 0010 (ADD): FETCH ir_w=pc_w=1 cyc1, DECODE cyc2, EXEC alu_op=10 cyc3, WB reg_w=1 reg_dst=1 cyc4; retired=1.
- LD with dmem_ready delayed 3 cycles: mem_r=1 held 4 cycles, then WB mem_to_reg=1; ST same delay returns to FETCH with no WB; retired +1 each.
- BEQ, BNE, JMP in sequence: beq, bne, j each high exactly one EXEC cycle with alu_op=01/01/xx; each 3 cycles; retired=3.
- imem_ready held low, TIMEOUT=16: ERROR entered after 16th low cycle, err=1, imem_r=0. Repeat with ready rising on cycle 16: DECODE, no error.
- Opcode 1010 -> ERROR from DECODE, retired unchanged. Opcode 1111 -> halted=1, stays HALT with run toggling.
- rst asserted in MEM waiting on dmem_ready: next cycle IDLE, all outputs 0, retired=0; later dmem_ready pulse ignored.
